// File: rtl/mc_stage_ctrl.sv
// Multi-cycle sequencing controller for the MIPS-subset CPU.
// Steps each instruction through IF/IFW/ID/EX/MEM/MEMW/WB and gates the
// static decoder controls into per-cycle enables. It also tracks the branch
// delay slot and counts retired instructions.
module mc_stage_ctrl #(
  parameter int unsigned INST_RAM_LAT = 1,
  parameter int unsigned DATA_RAM_LAT = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             br_taken,
  input  logic [4:0]       ctl_pcValue_mux,
  input  logic             ctl_dataRam_en,
  input  logic             ctl_dataRam_wen,
  input  logic             ctl_rf_wen,
  input  logic             ctl_rfWriteHigh_en,
  output logic             inst_ram_en,
  output logic             ir_wen,
  output logic             pc_wen,
  output logic [4:0]       pc_src_mux,
  output logic             tgt_wen,
  output logic             data_ram_en,
  output logic             data_ram_wen,
  output logic             rf_wen,
  output logic             rf_high_wen,
  output logic             retire,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] inst_count
);

  localparam int unsigned MAX_LAT = (INST_RAM_LAT > DATA_RAM_LAT) ? INST_RAM_LAT : DATA_RAM_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  localparam logic [CW-1:0] INST_LAST = CW'(INST_RAM_LAT - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_RAM_LAT - 1);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_IFW  = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_MEMW = 3'd5,
    S_WB   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             delay_pending_q, delay_pending_d;
  logic [CNT_W-1:0] inst_count_q, inst_count_d;

  logic             inst_ram_en_c, ir_wen_c, pc_wen_c, tgt_wen_c;
  logic             data_ram_en_c, data_ram_wen_c, rf_wen_c, rf_high_wen_c, retire_c;
  logic [4:0]       pc_src_mux_c;
  logic             jump;

  assign jump = ctl_pcValue_mux[2] | ctl_pcValue_mux[3] | (ctl_pcValue_mux[1] & br_taken);

  // Next-state and per-cycle enable decode from the registered state
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    delay_pending_d = delay_pending_q;
    inst_ram_en_c   = 1'b0;
    ir_wen_c        = 1'b0;
    pc_wen_c        = 1'b0;
    pc_src_mux_c    = '0;
    tgt_wen_c       = 1'b0;
    data_ram_en_c   = 1'b0;
    data_ram_wen_c  = 1'b0;
    rf_wen_c        = 1'b0;
    rf_high_wen_c   = 1'b0;
    retire_c        = 1'b0;
    case (state_q)
      S_IF: begin
        if (run) begin
          inst_ram_en_c = 1'b1;
          cnt_d         = '0;
          state_d       = S_IFW;
        end
      end
      S_IFW: begin
        inst_ram_en_c = 1'b1;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == INST_LAST) begin
          ir_wen_c = 1'b1;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        pc_wen_c        = 1'b1;
        pc_src_mux_c    = delay_pending_q ? 5'b10000 : 5'b00001;
        delay_pending_d = 1'b0;
        state_d         = S_EX;
      end
      S_EX: begin
        pc_src_mux_c = {1'b0, ctl_pcValue_mux[3:0]};
        if (jump) begin
          tgt_wen_c       = 1'b1;
          delay_pending_d = 1'b1;
        end
        if (ctl_dataRam_en) begin
          state_d = S_MEM;
        end else if (ctl_rf_wen) begin
          state_d = S_WB;
        end else begin
          retire_c = 1'b1;
          state_d  = S_IF;
        end
      end
      S_MEM: begin
        data_ram_en_c  = 1'b1;
        data_ram_wen_c = ctl_dataRam_wen;
        cnt_d          = '0;
        if (ctl_dataRam_wen) begin
          retire_c = 1'b1;
          state_d  = S_IF;
        end else begin
          state_d = S_MEMW;
        end
      end
      S_MEMW: begin
        data_ram_en_c = 1'b1;
        cnt_d         = cnt_q + 1'b1;
        if (cnt_q == DATA_LAST) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_wen_c      = 1'b1;
        rf_high_wen_c = ctl_rfWriteHigh_en;
        retire_c      = 1'b1;
        state_d       = S_IF;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
    inst_count_d = retire_c ? inst_count_q + CNT_W'(1) : inst_count_q;
  end

  // Sequencer state, latency counter, delay-slot flag and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IF;
      cnt_q           <= '0;
      delay_pending_q <= 1'b0;
      inst_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      delay_pending_q <= delay_pending_d;
      inst_count_q    <= inst_count_d;
    end
  end

  // Reset forces every output low, even before the first clock edge under reset
  always_comb begin
    inst_ram_en  = rst ? 1'b0 : inst_ram_en_c;
    ir_wen       = rst ? 1'b0 : ir_wen_c;
    pc_wen       = rst ? 1'b0 : pc_wen_c;
    pc_src_mux   = rst ? '0   : pc_src_mux_c;
    tgt_wen      = rst ? 1'b0 : tgt_wen_c;
    data_ram_en  = rst ? 1'b0 : data_ram_en_c;
    data_ram_wen = rst ? 1'b0 : data_ram_wen_c;
    rf_wen       = rst ? 1'b0 : rf_wen_c;
    rf_high_wen  = rst ? 1'b0 : rf_high_wen_c;
    retire       = rst ? 1'b0 : retire_c;
    state        = rst ? '0   : state_q;
    inst_count   = rst ? '0   : inst_count_q;
  end

endmodule

// File: tb/tb_mc_stage_ctrl.sv
// Directed bench for mc_stage_ctrl with INST_RAM_LAT=1, DATA_RAM_LAT=2.
// Every cycle's full output vector is compared to a hand-written expectation.
module tb_mc_stage_ctrl;

  logic        clk, rst, run, br_taken;
  logic [4:0]  ctl_pcValue_mux;
  logic        ctl_dataRam_en, ctl_dataRam_wen, ctl_rf_wen, ctl_rfWriteHigh_en;
  logic        inst_ram_en, ir_wen, pc_wen, tgt_wen;
  logic        data_ram_en, data_ram_wen, rf_wen, rf_high_wen, retire;
  logic [4:0]  pc_src_mux;
  logic [2:0]  state;
  logic [31:0] inst_count;
  logic [16:0] outs;

  int errors = 0;
  int checks = 0;

  mc_stage_ctrl #(.INST_RAM_LAT(1), .DATA_RAM_LAT(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .run(run), .br_taken(br_taken),
    .ctl_pcValue_mux(ctl_pcValue_mux), .ctl_dataRam_en(ctl_dataRam_en),
    .ctl_dataRam_wen(ctl_dataRam_wen), .ctl_rf_wen(ctl_rf_wen),
    .ctl_rfWriteHigh_en(ctl_rfWriteHigh_en),
    .inst_ram_en(inst_ram_en), .ir_wen(ir_wen), .pc_wen(pc_wen),
    .pc_src_mux(pc_src_mux), .tgt_wen(tgt_wen), .data_ram_en(data_ram_en),
    .data_ram_wen(data_ram_wen), .rf_wen(rf_wen), .rf_high_wen(rf_high_wen),
    .retire(retire), .state(state), .inst_count(inst_count)
  );

  assign outs = {inst_ram_en, ir_wen, pc_wen, pc_src_mux, tgt_wen, data_ram_en,
                 data_ram_wen, rf_wen, rf_high_wen, retire, state};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ire, irw, pcw, src[4:0], tgt, de, dw, rw, rhw, ret, state[2:0]}
  function automatic logic [16:0] ev(input int ire, input int irw, input int pcw,
                                     input int src, input int tgt, input int de,
                                     input int dw, input int rw, input int rhw,
                                     input int ret, input int st);
    return {1'(ire), 1'(irw), 1'(pcw), 5'(src), 1'(tgt), 1'(de), 1'(dw),
            1'(rw), 1'(rhw), 1'(ret), 3'(st)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ctl(input logic [4:0] pcm, input logic den, input logic dwen,
                         input logic rfw, input logic rfh, input logic br);
    ctl_pcValue_mux    = pcm;
    ctl_dataRam_en     = den;
    ctl_dataRam_wen    = dwen;
    ctl_rf_wen         = rfw;
    ctl_rfWriteHigh_en = rfh;
    br_taken           = br;
    #1;
  endtask

  // IF, IFW and ID of one instruction; id_src is the PC select expected in ID
  task automatic fetch(input string tag, input logic [4:0] id_src);
    chk({tag, "_if"},  32'(outs), 32'(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    step();
    chk({tag, "_ifw"}, 32'(outs), 32'(ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)));
    step();
    chk({tag, "_id"},  32'(outs), 32'(ev(0, 0, 1, id_src, 0, 0, 0, 0, 0, 0, 2)));
    step();
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b1;
    set_ctl(5'b00001, 0, 0, 1, 0, 0);
    step(); step(); step();
    chk("rst_outs", 32'(outs), 32'd0);
    chk("rst_cnt", inst_count, 32'd0);

    // ADD: 0,1,2,3,6
    rst = 1'b0;
    #1;
    fetch("add1", 5'b00001);
    chk("add1_ex", 32'(outs), 32'(ev(0, 0, 0, 5'b00001, 0, 0, 0, 0, 0, 0, 3)));
    step();
    chk("add1_wb", 32'(outs), 32'(ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6)));
    step();
    chk("add1_cnt", inst_count, 32'd1);

    // LW with DATA_RAM_LAT=2: 0,1,2,3,4,5,5,6
    set_ctl(5'b00001, 1, 0, 1, 0, 0);
    fetch("lw", 5'b00001);
    chk("lw_ex",    32'(outs), 32'(ev(0, 0, 0, 5'b00001, 0, 0, 0, 0, 0, 0, 3)));
    step();
    chk("lw_mem",   32'(outs), 32'(ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4)));
    step();
    chk("lw_memw1", 32'(outs), 32'(ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5)));
    step();
    chk("lw_memw2", 32'(outs), 32'(ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5)));
    step();
    chk("lw_wb",    32'(outs), 32'(ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6)));
    step();
    chk("lw_cnt", inst_count, 32'd2);

    // SW: retires from S_MEM
    set_ctl(5'b00001, 1, 1, 0, 0, 0);
    fetch("sw", 5'b00001);
    chk("sw_ex",  32'(outs), 32'(ev(0, 0, 0, 5'b00001, 0, 0, 0, 0, 0, 0, 3)));
    step();
    chk("sw_mem", 32'(outs), 32'(ev(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 4)));
    step();
    chk("sw_cnt", inst_count, 32'd3);

    // BEQ taken: target latched in EX, no rf write -> retire from EX
    set_ctl(5'b00010, 0, 0, 0, 0, 1);
    fetch("beqt", 5'b00001);
    chk("beqt_ex", 32'(outs), 32'(ev(0, 0, 0, 5'b00010, 1, 0, 0, 0, 0, 1, 3)));
    step();

    // Delay-slot instruction (writes HI as well): PC takes the target in its ID
    set_ctl(5'b00001, 0, 0, 1, 1, 0);
    fetch("slot1", 5'b10000);
    chk("slot1_ex", 32'(outs), 32'(ev(0, 0, 0, 5'b00001, 0, 0, 0, 0, 0, 0, 3)));
    step();
    chk("slot1_wb", 32'(outs), 32'(ev(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6)));
    step();
    chk("slot1_cnt", inst_count, 32'd5);

    // BEQ not taken: no target latch, next ID uses PC+4
    set_ctl(5'b00010, 0, 0, 0, 0, 0);
    fetch("beqn", 5'b00001);
    chk("beqn_ex", 32'(outs), 32'(ev(0, 0, 0, 5'b00010, 0, 0, 0, 0, 0, 1, 3)));
    step();
    set_ctl(5'b00001, 0, 0, 1, 0, 0);
    fetch("slot2", 5'b00001);
    chk("slot2_ex", 32'(outs), 32'(ev(0, 0, 0, 5'b00001, 0, 0, 0, 0, 0, 0, 3)));
    step();
    chk("slot2_wb", 32'(outs), 32'(ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6)));
    step();

    // J, then J in its delay slot, then ADD: both targets applied in turn
    set_ctl(5'b00100, 0, 0, 0, 0, 0);
    fetch("j1", 5'b00001);
    chk("j1_ex", 32'(outs), 32'(ev(0, 0, 0, 5'b00100, 1, 0, 0, 0, 0, 1, 3)));
    step();
    fetch("j2", 5'b10000);
    chk("j2_ex", 32'(outs), 32'(ev(0, 0, 0, 5'b00100, 1, 0, 0, 0, 0, 1, 3)));
    step();
    set_ctl(5'b00001, 0, 0, 1, 0, 0);
    fetch("add3", 5'b10000);
    chk("add3_ex", 32'(outs), 32'(ev(0, 0, 0, 5'b00001, 0, 0, 0, 0, 0, 0, 3)));
    step();
    chk("add3_wb", 32'(outs), 32'(ev(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6)));
    step();
    chk("add3_cnt", inst_count, 32'd10);

    // run=0 holds in S_IF with everything low
    run = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("idle_outs", 32'(outs), 32'd0);
      chk("idle_cnt", inst_count, 32'd10);
      step();
    end

    // Reset during S_MEM of a load abandons the access
    run = 1'b1;
    set_ctl(5'b00001, 1, 0, 1, 0, 0);
    fetch("lwr", 5'b00001);
    chk("lwr_ex",  32'(outs), 32'(ev(0, 0, 0, 5'b00001, 0, 0, 0, 0, 0, 0, 3)));
    step();
    chk("lwr_mem", 32'(outs), 32'(ev(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 4)));
    rst = 1'b1;
    #1;
    chk("lwr_rst_outs", 32'(outs), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("lwr_after", 32'(outs), 32'(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    chk("lwr_cnt", inst_count, 32'd0);
    step();
    chk("lwr_ifw", 32'(outs), 32'(ev(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_stage_ctrl.md
Name: mc_stage_ctrl

Overview:
- Multi-cycle sequencing controller for the MIPS-subset CPU.
- Steps each instruction through fetch, decode, execute, memory and write-back phases.
- Consumes the static per-instruction controls from the ID decoder; produces the per-cycle gated enables, IR/PC write strobes and the PC source select.
- Owns branch delay-slot bookkeeping and a retired-instruction counter.

Parameters:
INST_RAM_LAT, 1, instruction RAM read latency in cycles (>=1)
DATA_RAM_LAT, 1, data RAM read latency in cycles (>=1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
run  in  1  allow new fetch; sampled only in S_IF
br_taken  in  1  ALU branch-condition result, valid in S_EX
ctl_pcValue_mux  in  5  decoder PC select one-hot [PC+4, aluRes, instIndex, temp, delaySlot]; bit4 ignored
ctl_dataRam_en  in  1  decoder: instruction accesses data RAM
ctl_dataRam_wen  in  1  decoder: access is a store
ctl_rf_wen  in  1  decoder: instruction writes register file
ctl_rfWriteHigh_en  in  1  decoder: also write HI
inst_ram_en  out  1  instruction RAM enable
ir_wen  out  1  IR capture strobe
pc_wen  out  1  PC register write strobe
pc_src_mux  out  5  PC input select one-hot, same bit order as ctl_pcValue_mux
tgt_wen  out  1  latch jump/branch target into delay-target register
data_ram_en  out  1  gated data RAM enable
data_ram_wen  out  1  gated data RAM write enable
rf_wen  out  1  gated register-file write enable
rf_high_wen  out  1  gated HI write enable
retire  out  1  one-cycle pulse when instruction completes
state  out  3  current state encoding, for debug
inst_count  out  CNT_W  retired instruction count

Behaviour:
- Reset: sync, active-high; overrides all other activity.
  - state=S_IF, wait counter=0, delay_pending=0, inst_count=0.
  - While rst=1, every output is 0.
- States and encodings: S_IF=0, S_IFW=1, S_ID=2, S_EX=3, S_MEM=4, S_MEMW=5, S_WB=6. Code 7 is illegal and goes to S_IF.
- Outputs are combinational decodes of the registered state plus the decoder inputs; no added latency.
- S_IF:
  - run=0: hold in S_IF with all outputs 0.
  - run=1: inst_ram_en=1, wait counter cleared; next S_IFW.
- S_IFW:
  - inst_ram_en=1; counter counts up.
  - On cycle INST_RAM_LAT, ir_wen=1; next S_ID. Total fetch is 1+INST_RAM_LAT cycles.
- S_ID:
  - pc_wen=1 with pc_src_mux=00001 (PC+4) when delay_pending=0.
  - When delay_pending=1, pc_src_mux=10000 (delay target) and delay_pending clears.
  - Next S_EX.
- S_EX:
  - jump = ctl_pcValue_mux[2] | ctl_pcValue_mux[3] | (ctl_pcValue_mux[1] & br_taken).
  - If jump: tgt_wen=1, delay_pending set at end of cycle.
  - Target select for the datapath is ctl_pcValue_mux, passed through on pc_src_mux during S_EX only. pc_wen=0 in S_EX.
  - Next state: ctl_dataRam_en → S_MEM; else ctl_rf_wen → S_WB; else retire=1 → S_IF.
- S_MEM:
  - data_ram_en=1, data_ram_wen=ctl_dataRam_wen.
  - Store: retire=1 → S_IF.
  - Load: next S_MEMW.
- S_MEMW: data_ram_en=1; after DATA_RAM_LAT cycles → S_WB.
- S_WB: rf_wen=1, rf_high_wen=ctl_rfWriteHigh_en; retire=1 → S_IF.
- inst_count increments by 1 on every retire and wraps modulo 2^CNT_W.
- Delay slot: a jump in S_EX of instruction N makes N+1 fetch from PC+4; PC takes the target in S_ID of N+1.
  - A jump in a delay slot: S_ID of the slot instruction clears delay_pending before its own S_EX sets it again. The second target therefore takes effect after its own slot; no target is lost.
- Reset mid-instruction: any pending access is abandoned (no enable asserted in the cycle after rst), delay_pending is lost, count restarts at 0.
- Cycle counts at LAT=1: ALU op 5, store 5, jump (no rf write) 4, load 7.

Test Plan:
- rst held 3 cycles, then ADD (rf_wen=1) with run=1 → states 0,1,2,3,6,0; ir_wen at cycle 2, pc_wen/PC+4 at cycle 3, rf_wen at cycle 5, retire once, inst_count=1.
- LW (dataRam_en=1, wen=0, rf_wen=1), DATA_RAM_LAT=2 → path 0,1,2,3,4,5,5,6; data_ram_en high 3 cycles, data_ram_wen=0, rf_wen 1 cycle.
- SW (dataRam_en=1, wen=1) → S_MEM with data_ram_en=data_ram_wen=1, retire in S_MEM, rf_wen never asserted.
- BEQ taken (pcValue_mux=00010, br_taken=1) then ADD → tgt_wen in BEQ S_EX; ADD S_ID drives pc_src_mux=10000. Same with br_taken=0 → 00001, tgt_wen=0.
- J followed by J in delay slot → first target applied in second J's S_ID; second target applied in S_ID of the following instruction.
- run=0 for 4 cycles in S_IF → all outputs 0, state 0, inst_count unchanged. rst asserted in S_MEM of a load → next cycle state=0, data_ram_en=0, rf_wen=0, inst_count=0.
